pipe_hazard_ctrl: RTL and testbench

//   Parametrised hazard/stall/flush/forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and ID-stage forwarding control for a 5-stage pipeline.
// Includes a variable-latency data-memory wait FSM with a timeout watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_re1_i,
    input  logic            id_re2_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic            ex_we_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            ex_is_load_i,
    input  logic [XLEN-1:0] ex_wd_i,
    input  logic            mem_we_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0] mem_wd_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_wd_i,
    input  logic            ex_redirect_i,
    input  logic            mem_req_i,
    input  logic            mem_ready_i,
    output logic            stall_pc_o,
    output logic            stall_if_id_o,
    output logic            stall_id_ex_o,
    output logic            stall_ex_mem_o,
    output logic            stall_mem_wb_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            flush_ex_mem_o,
    output logic            flush_mem_wb_o,
    output logic [1:0]      fwd1_sel_o,
    output logic [XLEN-1:0] fwd1_data_o,
    output logic [1:0]      fwd2_sel_o,
    output logic [XLEN-1:0] fwd2_data_o,
    output logic            mem_busy_o,
    output logic            mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_W = WCNT_W'(TIMEOUT);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} mem_state_e;

    mem_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_stall_s, lu_s, redirect_take_s;
    logic [8:0]        ctrl_s;

    // Forwarding priority: youngest producer first; EX loads have no data yet.
    function automatic logic [1:0] fwd_sel_f(
        input logic re, input logic [RA_W-1:0] rs,
        input logic exw, input logic exl, input logic [RA_W-1:0] exd,
        input logic mw, input logic [RA_W-1:0] md,
        input logic ww, input logic [RA_W-1:0] wd);
        logic [1:0] sel;
        sel = 2'd0;
        if (!re || rs == '0)          sel = 2'd0;
        else if (exw && !exl && exd == rs) sel = 2'd1;
        else if (mw && md == rs)      sel = 2'd2;
        else if (ww && wd == rs)      sel = 2'd3;
        else                          sel = 2'd0;
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] fwd_data_f(input logic [1:0] sel,
        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
        logic [XLEN-1:0] d;
        case (sel)
            2'd1:    d = a;
            2'd2:    d = b;
            2'd3:    d = c;
            default: d = '0;
        endcase
        return d;
    endfunction

    // Memory wait FSM next state, watchdog counter and sticky error.
    always_comb begin
        state_d = state_q;
        wcnt_d  = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i && !mem_ready_i) state_d = ST_WAIT;
                else                           state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (wcnt_q != TIMEOUT_W) wcnt_d = wcnt_q + 1'b1;
                else                     wcnt_d = wcnt_q;
                if (wcnt_d == TIMEOUT_W) err_d = 1'b1;
                else                     err_d = err_q;
                if (mem_ready_i) state_d = ST_IDLE;
                else             state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_stall_s = mem_req_i & ~mem_ready_i;
    assign lu_s = ex_we_i & ex_is_load_i & (ex_rd_i != '0) &
                  ((id_re1_i & (id_rs1_i == ex_rd_i)) | (id_re2_i & (id_rs2_i == ex_rd_i)));

    // Stall/flush priority; ctrl_s = {stall pc,if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex,ex_mem,mem_wb}.
    always_comb begin
        ctrl_s          = 9'b0;
        redirect_take_s = 1'b0;
        if (rst_i) begin
            ctrl_s = 9'b0;
        end else if (mem_stall_s) begin
            ctrl_s = 9'b11110_0001;
        end else if (ex_redirect_i) begin
            ctrl_s          = 9'b00000_1100;
            redirect_take_s = 1'b1;
        end else if (lu_s) begin
            ctrl_s = 9'b11000_0100;
        end else begin
            ctrl_s = 9'b0;
        end
    end

    assign {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
            flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o} = ctrl_s;

    // Operand forwarding; selections forced to regfile while in reset.
    always_comb begin
        fwd1_sel_o = 2'd0;
        fwd2_sel_o = 2'd0;
        if (rst_i) begin
            fwd1_sel_o = 2'd0;
            fwd2_sel_o = 2'd0;
        end else begin
            fwd1_sel_o = fwd_sel_f(id_re1_i, id_rs1_i, ex_we_i, ex_is_load_i, ex_rd_i,
                                   mem_we_i, mem_rd_i, wb_we_i, wb_rd_i);
            fwd2_sel_o = fwd_sel_f(id_re2_i, id_rs2_i, ex_we_i, ex_is_load_i, ex_rd_i,
                                   mem_we_i, mem_rd_i, wb_we_i, wb_rd_i);
        end
        fwd1_data_o = fwd_data_f(fwd1_sel_o, ex_wd_i, mem_wd_i, wb_wd_i);
        fwd2_data_o = fwd_data_f(fwd2_sel_o, ex_wd_i, mem_wd_i, wb_wd_i);
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_pc_o && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
        else                                            stall_cnt_d = stall_cnt_q;
        if (redirect_take_s && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
        else                                                 flush_cnt_d = flush_cnt_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_busy_o  = (state_q == ST_WAIT);
    assign mem_err_o   = err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;
    localparam int XLEN = 32, RA_W = 5, TIMEOUT = 4, CNT_W = 3;
    localparam int CNT_MAX = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, id_re1, id_re2, ex_we, ex_is_load, mem_we, wb_we, ex_redirect, mem_req, mem_ready;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic [XLEN-1:0] ex_wd, mem_wd, wb_wd;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_busy, mem_err;
    logic [1:0] fwd1_sel, fwd2_sel;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .id_re1_i(id_re1), .id_re2_i(id_re2),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_we_i(ex_we), .ex_rd_i(ex_rd),
        .ex_is_load_i(ex_is_load), .ex_wd_i(ex_wd), .mem_we_i(mem_we), .mem_rd_i(mem_rd),
        .mem_wd_i(mem_wd), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
        .ex_redirect_i(ex_redirect), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id), .stall_id_ex_o(stall_id_ex),
        .stall_ex_mem_o(stall_ex_mem), .stall_mem_wb_o(stall_mem_wb),
        .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
        .flush_ex_mem_o(flush_ex_mem), .flush_mem_wb_o(flush_mem_wb),
        .fwd1_sel_o(fwd1_sel), .fwd1_data_o(fwd1_data), .fwd2_sel_o(fwd2_sel),
        .fwd2_data_o(fwd2_data), .mem_busy_o(mem_busy), .mem_err_o(mem_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

    typedef struct {
        logic rst, re1, re2, ex_we, ex_load, mem_we, wb_we, redirect, mem_req, mem_ready;
        logic [RA_W-1:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
        logic [XLEN-1:0] ex_wd, mem_wd, wb_wd;
    } stim_t;

    typedef struct {
        logic [8:0] ctrl;
        logic [1:0] s1, s2;
        logic [XLEN-1:0] d1, d2;
        logic busy, err;
        int scnt, fcnt;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0, failures = 0;

    // Reference model state, kept as plain integers and flags.
    bit m_wait = 0, m_err = 0;
    int m_wcnt = 0, m_scnt = 0, m_fcnt = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic void fwd_model(input stim_t s, input logic re, input logic [RA_W-1:0] rs,
                                      output logic [1:0] sel, output logic [XLEN-1:0] d);
        logic            we [3];
        logic [RA_W-1:0] rd [3];
        logic [XLEN-1:0] wd [3];
        bit found;
        we[0] = s.ex_we && !s.ex_load; rd[0] = s.ex_rd;  wd[0] = s.ex_wd;
        we[1] = s.mem_we;              rd[1] = s.mem_rd; wd[1] = s.mem_wd;
        we[2] = s.wb_we;               rd[2] = s.wb_rd;  wd[2] = s.wb_wd;
        sel = 2'd0; d = '0; found = 0;
        if (re && rs != 0 && !s.rst)
            for (int p = 0; p < 3; p++)
                if (!found && we[p] && rd[p] == rs) begin
                    sel = 2'(p + 1); d = wd[p]; found = 1;
                end
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit mstall, lu, take;
        rst = s.rst; id_re1 = s.re1; id_re2 = s.re2; id_rs1 = s.rs1; id_rs2 = s.rs2;
        ex_we = s.ex_we; ex_is_load = s.ex_load; ex_rd = s.ex_rd; ex_wd = s.ex_wd;
        mem_we = s.mem_we; mem_rd = s.mem_rd; mem_wd = s.mem_wd;
        wb_we = s.wb_we; wb_rd = s.wb_rd; wb_wd = s.wb_wd;
        ex_redirect = s.redirect; mem_req = s.mem_req; mem_ready = s.mem_ready;

        mstall = s.mem_req && !s.mem_ready;
        lu = s.ex_we && s.ex_load && s.ex_rd != 0 &&
             ((s.re1 && s.rs1 == s.ex_rd) || (s.re2 && s.rs2 == s.ex_rd));
        take = 0;
        if (s.rst)           e.ctrl = 9'b0;
        else if (mstall)     e.ctrl = 9'b11110_0001;
        else if (s.redirect) begin e.ctrl = 9'b00000_1100; take = 1; end
        else if (lu)         e.ctrl = 9'b11000_0100;
        else                 e.ctrl = 9'b0;
        fwd_model(s, s.re1, s.rs1, e.s1, e.d1);
        fwd_model(s, s.re2, s.rs2, e.s2, e.d2);
        e.busy = m_wait; e.err = m_err; e.scnt = m_scnt; e.fcnt = m_fcnt;
        sb_q.push_back(e);

        // Advance the model across the coming clock edge.
        if (s.rst) begin
            m_wait = 0; m_err = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (m_wait) begin
                m_wcnt++;
                if (m_wcnt >= TIMEOUT) m_err = 1;
                if (s.mem_ready) m_wait = 0;
            end else begin
                m_wcnt = 0;
                if (mstall) m_wait = 1;
            end
            if (e.ctrl[8] && m_scnt < CNT_MAX) m_scnt++;
            if (take && m_fcnt < CNT_MAX) m_fcnt++;
        end
        @(posedge clk); #1;
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("ctrl", {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}, e.ctrl);
                check("fwd1", {fwd1_sel, fwd1_data}, {e.s1, e.d1});
                check("fwd2", {fwd2_sel, fwd2_data}, {e.s2, e.d2});
                check("busy_err", {mem_busy, mem_err}, {e.busy, e.err});
                check("stall_cnt", stall_cnt, e.scnt);
                check("flush_cnt", flush_cnt, e.fcnt);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle_stim();
        s.rst = 1;
        rst = 1; id_re1 = 0; id_re2 = 0; id_rs1 = 0; id_rs2 = 0; ex_we = 0; ex_is_load = 0;
        ex_rd = 0; ex_wd = 0; mem_we = 0; mem_rd = 0; mem_wd = 0; wb_we = 0; wb_rd = 0;
        wb_wd = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk); #1;
        repeat (2) drive(s);

        // EX beats MEM when both write the same source register.
        s = idle_stim();
        s.re1 = 1; s.rs1 = 5'd3; s.ex_we = 1; s.ex_rd = 5'd3; s.ex_wd = 32'h11;
        s.mem_we = 1; s.mem_rd = 5'd3; s.mem_wd = 32'h22;
        drive(s);

        // Load-use: one stall cycle, then forward from MEM.
        s = idle_stim();
        s.re1 = 1; s.rs1 = 5'd7; s.ex_we = 1; s.ex_load = 1; s.ex_rd = 5'd7;
        drive(s);
        s = idle_stim();
        s.re1 = 1; s.rs1 = 5'd7; s.mem_we = 1; s.mem_rd = 5'd7; s.mem_wd = 32'hCAFE_0007;
        drive(s);

        // Memory wait of three cycles.
        s = idle_stim(); s.mem_req = 1;
        repeat (3) drive(s);
        s.mem_ready = 1; drive(s);
        s = idle_stim(); drive(s);

        // Redirect masked during a memory stall, accepted once released.
        s = idle_stim(); s.mem_req = 1; s.redirect = 1;
        repeat (2) drive(s);
        s.mem_ready = 1; drive(s);
        s = idle_stim(); drive(s);

        // Watchdog timeout, error stays after ready, cleared by reset.
        s = idle_stim(); s.mem_req = 1;
        repeat (7) drive(s);
        s.mem_ready = 1; drive(s);
        s = idle_stim(); repeat (2) drive(s);
        s.rst = 1; drive(s);
        s.rst = 0; drive(s);

        // Nine load-use stalls saturate the 3-bit stall counter.
        s = idle_stim();
        s.re2 = 1; s.rs2 = 5'd9; s.ex_we = 1; s.ex_load = 1; s.ex_rd = 5'd9;
        repeat (9) drive(s);
        s = idle_stim(); drive(s);

        // Randomized traffic with small register space to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            s.rst       = ($urandom_range(0, 99) < 2);
            s.re1       = 1'($urandom);
            s.re2       = 1'($urandom);
            s.rs1       = RA_W'($urandom_range(0, 3));
            s.rs2       = RA_W'($urandom_range(0, 3));
            s.ex_we     = 1'($urandom);
            s.ex_load   = ($urandom_range(0, 99) < 30);
            s.ex_rd     = RA_W'($urandom_range(0, 3));
            s.ex_wd     = $urandom;
            s.mem_we    = 1'($urandom);
            s.mem_rd    = RA_W'($urandom_range(0, 3));
            s.mem_wd    = $urandom;
            s.wb_we     = 1'($urandom);
            s.wb_rd     = RA_W'($urandom_range(0, 3));
            s.wb_wd     = $urandom;
            s.redirect  = ($urandom_range(0, 99) < 15);
            s.mem_req   = ($urandom_range(0, 99) < 40);
            s.mem_ready = ($urandom_range(0, 99) < (i < 1500 ? 60 : 15));
            drive(s);
        end

        s = idle_stim(); drive(s);
        @(negedge clk); #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
